// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file geometry and scoreboard sizing.
// Imported by the scoreboard, the register file and the pipeline stages.
package regfile_scoreboard_pkg;

  localparam int ADDR_WID = 4;
  localparam int DATA_WID = 32;
  localparam int CNT_WID  = 2;
  localparam int REG_CNT  = 1 << ADDR_WID;

  localparam logic [ADDR_WID-1:0] RNONE = 4'hF;

  typedef logic [ADDR_WID-1:0] regId_t;

  // Writes that go through the two register-file write ports in one cycle.
  typedef struct packed {
    logic   valid;
    regId_t destE;
    regId_t destM;
  } wrReq_t;

endpackage

// File: rtl/regfile_sb_counter.sv
// One pending-write counter: adds issues and subtracts retires in a single update.
// A retire that would take the count below zero leaves it at zero and pulses underflow.
module regfile_sb_counter #(
  parameter int CNT_WID = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [1:0]         inc,
  input  logic [1:0]         dec,
  input  logic               clr,
  output logic [CNT_WID-1:0] count,
  output logic               nonzero,
  output logic               underflow
);

  logic [CNT_WID+1:0] sum;
  logic [CNT_WID+1:0] decExt;

  assign sum       = {2'b00, count} + {{CNT_WID{1'b0}}, inc};
  assign decExt    = {{CNT_WID{1'b0}}, dec};
  // A flush discards the retire, so it must not raise an error either.
  assign underflow = ~clr & (decExt > sum);
  assign nonzero   = |count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         count <= '0;
    else if (clr)       count <= '0;
    else if (underflow) count <= '0;
    else                count <= CNT_WID'(sum - decExt);
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard: counts pending writes per register, stalls decode on
// read-after-write hazards and on counter overflow, counts down on write-back.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int                       ADDR_WID = regfile_scoreboard_pkg::ADDR_WID,
  parameter int                       CNT_WID  = regfile_scoreboard_pkg::CNT_WID,
  parameter logic [ADDR_WID-1:0]      RNONE    = regfile_scoreboard_pkg::RNONE
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [ADDR_WID-1:0]         srcA,
  input  logic [ADDR_WID-1:0]         srcB,
  input  logic                        issue_valid,
  input  logic [ADDR_WID-1:0]         issue_destE,
  input  logic [ADDR_WID-1:0]         issue_destM,
  output logic                        issue_ready,
  input  logic                        wb_valid,
  input  logic [ADDR_WID-1:0]         wb_destE,
  input  logic [ADDR_WID-1:0]         wb_destM,
  input  logic                        clr,
  output logic [(1<<ADDR_WID)-1:0]    busy,
  output logic                        err_underflow
);

  localparam int                 NREG    = 1 << ADDR_WID;
  localparam logic [CNT_WID+1:0] CNT_LIM = (CNT_WID+2)'((1 << CNT_WID) - 1);

  logic [NREG-1:0] nz;
  logic [NREG-1:0] ovfR;
  logic [NREG-1:0] udf;
  logic            hazA, hazB, ovf, accept;

  // Hazards look only at registered counts; a retire this cycle does not bypass.
  assign hazA        = (srcA != RNONE) && nz[srcA];
  assign hazB        = (srcB != RNONE) && nz[srcB];
  assign ovf         = |ovfR;
  assign issue_ready = ~hazA & ~hazB & ~ovf & ~clr;
  assign accept      = issue_valid & issue_ready;
  assign busy        = nz;

  for (genvar r = 0; r < NREG; r++) begin : gSlot
    localparam logic [ADDR_WID-1:0] ID = ADDR_WID'(r);
    if (ID == RNONE) begin : gNone
      assign nz[r]   = 1'b0;
      assign ovfR[r] = 1'b0;
      assign udf[r]  = 1'b0;
    end else begin : gCnt
      logic [1:0]         incReq, incAcc, decReq;
      logic [CNT_WID-1:0] count;

      assign incReq  = 2'(issue_destE == ID) + 2'(issue_destM == ID);
      assign incAcc  = accept   ? incReq : 2'd0;
      assign decReq  = wb_valid ? (2'(wb_destE == ID) + 2'(wb_destM == ID)) : 2'd0;
      // Conservative: a retire in the same cycle does not make room.
      assign ovfR[r] = ({2'b00, count} + {{CNT_WID{1'b0}}, incReq}) > CNT_LIM;

      regfile_sb_counter #(.CNT_WID(CNT_WID)) uCnt (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .inc       (incAcc),
        .dec       (decReq),
        .clr       (clr),
        .count     (count),
        .nonzero   (nz[r]),
        .underflow (udf[r])
      );
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    err_underflow <= 1'b0;
    else if (|udf) err_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for the register-file scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  srcA, srcB, issue_destE, issue_destM, wb_destE, wb_destM;
  logic        issue_valid, wb_valid, clr;
  logic        issue_ready, err_underflow;
  logic [15:0] busy;

  int vecs = 0;
  int errs = 0;

  regfile_scoreboard dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .srcA          (srcA),
    .srcB          (srcB),
    .issue_valid   (issue_valid),
    .issue_destE   (issue_destE),
    .issue_destM   (issue_destM),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_destE      (wb_destE),
    .wb_destM      (wb_destM),
    .clr           (clr),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    srcA = 4'hF; srcB = 4'hF;
    issue_valid = 1'b0; issue_destE = 4'hF; issue_destM = 4'hF;
    wb_valid = 1'b0; wb_destE = 4'hF; wb_destM = 4'hF;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    RST_N = 1'b0;
    #3;
    vecs++; if (busy !== 16'h0000) begin errs++; $display("FAIL reset_busy got %h exp %h", busy, 16'h0000); end
    vecs++; if (err_underflow !== 1'b0) begin errs++; $display("FAIL reset_err got %b exp 0", err_underflow); end
    vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", issue_ready); end
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_raw();
    idle();
    issue_valid = 1'b1; issue_destE = 4'd3;
    #1;
    vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL raw_issue_ready got %b exp 1", issue_ready); end
    tick();
    idle(); srcA = 4'd3;
    #1;
    vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL raw_stall got %b exp 0", issue_ready); end
    vecs++; if (busy !== 16'h0008) begin errs++; $display("FAIL raw_busy got %h exp %h", busy, 16'h0008); end
    wb_valid = 1'b1; wb_destE = 4'd3;
    #1;
    vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL raw_no_bypass got %b exp 0", issue_ready); end
    tick();
    wb_valid = 1'b0; wb_destE = 4'hF;
    #1;
    vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL raw_release got %b exp 1", issue_ready); end
    vecs++; if (busy !== 16'h0000) begin errs++; $display("FAIL raw_busy_clear got %h exp %h", busy, 16'h0000); end
    // srcB hazard back to back with the issue
    idle(); issue_valid = 1'b1; issue_destM = 4'd9;
    tick();
    idle(); srcA = 4'd3; srcB = 4'd9;
    #1;
    vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL rawB_stall got %b exp 0", issue_ready); end
    vecs++; if (busy !== 16'h0200) begin errs++; $display("FAIL rawB_busy got %h exp %h", busy, 16'h0200); end
    idle(); wb_valid = 1'b1; wb_destM = 4'd9;
    tick();
    idle();
  endtask

  task automatic test_overflow();
    idle();
    issue_valid = 1'b1; issue_destE = 4'd5;
    for (int i = 0; i < 2; i++) tick();
    // cnt[5]=2: a dual-port issue to 5 would reach 4
    issue_destM = 4'd5;
    #1;
    vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL ovf_dual got %b exp 0", issue_ready); end
    issue_destM = 4'hF;
    #1;
    vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL ovf_third got %b exp 1", issue_ready); end
    tick();
    #1;
    vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL ovf_fourth got %b exp 0", issue_ready); end
    vecs++; if (busy !== 16'h0020) begin errs++; $display("FAIL ovf_busy got %h exp %h", busy, 16'h0020); end
    tick();
    idle(); wb_valid = 1'b1; wb_destE = 4'd5;
    // blocked fourth issue must not have counted: three retires drain it
    for (int i = 0; i < 3; i++) tick();
    idle();
    #1;
    vecs++; if (busy !== 16'h0000) begin errs++; $display("FAIL ovf_drain got %h exp %h", busy, 16'h0000); end
    vecs++; if (err_underflow !== 1'b0) begin errs++; $display("FAIL ovf_drain_err got %b exp 0", err_underflow); end
  endtask

  task automatic test_net();
    idle(); issue_valid = 1'b1; issue_destE = 4'd2;
    tick();
    wb_valid = 1'b1; wb_destE = 4'd2;
    tick();
    idle();
    #1;
    vecs++; if (busy !== 16'h0004) begin errs++; $display("FAIL net_busy got %h exp %h", busy, 16'h0004); end
    wb_valid = 1'b1; wb_destE = 4'd2;
    tick();
    idle();
    #1;
    vecs++; if (busy !== 16'h0000) begin errs++; $display("FAIL net_drain got %h exp %h", busy, 16'h0000); end
    vecs++; if (err_underflow !== 1'b0) begin errs++; $display("FAIL net_err got %b exp 0", err_underflow); end
  endtask

  task automatic test_dual();
    idle(); issue_valid = 1'b1; issue_destE = 4'd4; issue_destM = 4'd4;
    tick();
    idle(); srcB = 4'd4;
    #1;
    vecs++; if (busy !== 16'h0010) begin errs++; $display("FAIL dual_busy got %h exp %h", busy, 16'h0010); end
    vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL dual_stall got %b exp 0", issue_ready); end
    wb_valid = 1'b1; wb_destE = 4'd4; wb_destM = 4'd4;
    tick();
    idle();
    #1;
    vecs++; if (busy !== 16'h0000) begin errs++; $display("FAIL dual_wb got %h exp %h", busy, 16'h0000); end
    vecs++; if (err_underflow !== 1'b0) begin errs++; $display("FAIL dual_err got %b exp 0", err_underflow); end
  endtask

  task automatic test_underflow();
    idle(); wb_valid = 1'b1; wb_destE = 4'd7;
    tick();
    idle();
    #1;
    vecs++; if (err_underflow !== 1'b1) begin errs++; $display("FAIL udf_set got %b exp 1", err_underflow); end
    vecs++; if (busy !== 16'h0000) begin errs++; $display("FAIL udf_busy got %h exp %h", busy, 16'h0000); end
    tick(); tick();
    vecs++; if (err_underflow !== 1'b1) begin errs++; $display("FAIL udf_sticky got %b exp 1", err_underflow); end
  endtask

  task automatic test_clr();
    idle(); issue_valid = 1'b1; issue_destE = 4'd1; issue_destM = 4'd1;
    tick();
    issue_destE = 4'd6; issue_destM = 4'hF;
    tick();
    idle();
    #1;
    vecs++; if (busy !== 16'h0042) begin errs++; $display("FAIL clr_pre_busy got %h exp %h", busy, 16'h0042); end
    clr = 1'b1; issue_valid = 1'b1; issue_destE = 4'd3;
    #1;
    vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL clr_ready got %b exp 0", issue_ready); end
    tick();
    idle();
    #1;
    vecs++; if (busy !== 16'h0000) begin errs++; $display("FAIL clr_busy got %h exp %h", busy, 16'h0000); end
    vecs++; if (err_underflow !== 1'b1) begin errs++; $display("FAIL clr_err_kept got %b exp 1", err_underflow); end
    #1;
    RST_N = 1'b0;
    #1;
    vecs++; if (err_underflow !== 1'b0) begin errs++; $display("FAIL async_rst_err got %b exp 0", err_underflow); end
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_overflow();
    test_net();
    test_dual();
    test_underflow();
    test_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Issue-side scheduler for the register file (two read ports srcA/srcB, two write ports destE/destM).
- Tracks in-flight writes per architectural register and stalls decode while a source register still has a pending write.
- Sits between decode and the register file: counts up on issue, counts down on write-back.
- Gives a correct register read without forwarding; forwarding can later narrow the stall.

Parameters:
- ADDR_WID, 4, register-ID width; number of registers = 2**ADDR_WID.
- CNT_WID, 2, per-register pending-write counter width; max in-flight = 2**CNT_WID-1 (3).
- RNONE, 4'hF, "no register" ID; never tracked, never stalls.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- srcA  in  ADDR_WID  decode read-port A register ID.
- srcB  in  ADDR_WID  decode read-port B register ID.
- issue_valid  in  1  decode wants to issue the current instruction.
- issue_destE  in  ADDR_WID  E-port destination of the issuing instruction.
- issue_destM  in  ADDR_WID  M-port destination of the issuing instruction.
- issue_ready  out  1  issue accepted this cycle if issue_valid is high (combinational).
- wb_valid  in  1  write-back stage retiring an instruction this cycle.
- wb_destE  in  ADDR_WID  E-port register written back.
- wb_destM  in  ADDR_WID  M-port register written back.
- clr  in  1  synchronous flush; zeroes all counters.
- busy  out  2**ADDR_WID  bit r = counter[r] != 0 (registered).
- err_underflow  out  1  sticky; set on a retire against a zero counter.

Behaviour:
- Reset (RST_N low, async): all counters 0, busy = 0, err_underflow = 0. issue_ready then follows the combinational rule.
- Hazards:
  - hazA = (srcA != RNONE) && cnt[srcA] != 0; hazB likewise for srcB.
  - Both use registered counts only. No same-cycle retire bypass: a retire at edge N clears the stall from cycle N+1.
- Overflow block:
  - ovf = for either dest d != RNONE, cnt[d] + inc[d] > max.
  - inc[d] = number of issue ports naming d (1 or 2; destE == destM counts 2).
  - Same-cycle retire is deliberately ignored (conservative).
- issue_ready = ~hazA & ~hazB & ~ovf & ~clr.
- Accepted issue = issue_valid & issue_ready. It adds inc[r] to each non-RNONE named register.
- Retire (wb_valid):
  - Subtracts 1 from cnt[wb_destE] and 1 from cnt[wb_destM] (2 if equal), skipping RNONE.
  - If a decrement would drop below 0: counter saturates at 0 and err_underflow sets. It clears only on reset.
- Per-register next value = cnt + inc_acc - dec, with a single write per cycle. Simultaneous issue and retire of the same register nets out; e.g. 1 +1 -1 = 1.
- clr has priority over issue and retire in the same cycle: all counters go to 0 and err_underflow is unchanged.
- busy updates with the counters (same edge), so it reflects post-edge state.
- Latency: counters update one edge after the accept or retire. issue_ready is combinational from srcA/srcB/dest inputs and the registered state.
- Register-ID wrap is not applicable: all IDs are in range, and RNONE is the only excluded value.

Decomposition:
- head.v holds ADDR_WID, DATA_WID, RNONE and the derived REG_CNT, shared with the register file and pipeline stages.
- One sub-module: regfile_sb_counter, a single CNT_WID up/down counter.
  - Inputs: inc (0..2), dec (0..2), clr.
  - Outputs: count, nonzero, underflow pulse.
  - Instantiated REG_CNT-1 times by generate (RNONE slot tied to 0).

Test Plan:
- Reset, then issue destE=3, destM=RNONE; next cycle srcA=3 -> issue_ready=0, busy=16'h0008; wb_destE=3 -> the following cycle issue_ready=1, busy=0.
- Issue destE=5 three times, srcA/srcB=RNONE -> cnt[5]=3; fourth issue with destE=5 -> issue_ready=0 (ovf) while srcA/srcB don't hazard.
- cnt[2]=1; same cycle issue destE=2 and wb_destE=2 -> cnt[2] stays 1, busy bit 2 stays 1.
- Issue destE=4, destM=4 -> cnt[4]=2; a single wb with destE=4, destM=4 -> cnt[4]=0.
- With all counts 0, wb_valid with wb_destE=7 -> err_underflow=1 and sticky; cnt[7] stays 0.
- cnt[1]=2, cnt[6]=1; assert clr together with issue_valid -> issue_ready=0, next cycle busy=0. Then pull RST_N low mid-cycle -> err_underflow=0 immediately.
